// File: rtl/autobaud_pkg.sv
// autobaud_pkg: shared types, widths and the divisor rounding helper for
// the autobaud detector.
//   state_t     - detector FSM states
//   CNT_W       - low-run counter width (bit-time measurement in clk cycles)
//   IDLE_W      - continuous-high counter width (covers cnt << OVS_SHIFT)
//   DVSR_W      - divisor width driven to the baud generator
//   OVS_SHIFT   - log2 of the 16x oversampling ratio
//   round_dvsr  - cycles-per-bit -> clamped, half-up rounded 16x divisor
package autobaud_pkg;

    typedef enum logic [2:0] {
        IDLE_WAIT,
        WAIT_START,
        MEASURE,
        SKIP,
        LOCKED
    } state_t;

    localparam int CNT_W     = 16;
    localparam int IDLE_W    = 20;
    localparam int DVSR_W    = 12;
    localparam int OVS_SHIFT = 4;

    localparam logic [DVSR_W-1:0] DVSR_MIN = DVSR_W'(2);
    localparam logic [DVSR_W-1:0] DVSR_MAX = DVSR_W'((1 << DVSR_W) - 1);

    // Adding half an oversample tick before the shift gives exact half-up
    // rounding; the extra bit keeps cnt = 2^CNT_W - 1 from wrapping.
    function automatic logic [DVSR_W-1:0] round_dvsr(input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] sum;
        logic [CNT_W:0] quo;
        sum = {1'b0, cnt} + (CNT_W+1)'(1 << (OVS_SHIFT - 1));
        quo = sum >> OVS_SHIFT;
        if (quo < (CNT_W+1)'(DVSR_MIN)) begin
            return DVSR_MIN;
        end else if (quo > (CNT_W+1)'(DVSR_MAX)) begin
            return DVSR_MAX;
        end else begin
            return quo[DVSR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/autobaud_detector_rx_sync.sv
// rx_sync: two-flop synchronizer for the raw rx line plus a registered copy
// of the synchronized value for edge detection. All flops reset high so a
// reset never looks like a falling edge on an idle line.
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_rx           - raw asynchronous serial input
//   o_rx_s         - synchronized rx
//   o_fall/o_rise  - one-cycle edge strobes on o_rx_s
module rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_prev & ~r_sync;
    assign o_rise = ~r_prev & r_sync;

endmodule

// File: rtl/autobaud_detector.sv
// autobaud_detector: measures the start-bit width of a sync character
// (bit0 = 1, so the first low run is exactly one bit) and produces the 16x
// oversampling divisor for the baud generator.
//   i_clk, i_rst   - clock, asynchronous active-high reset
//   i_rx           - raw serial line, idle high
//   i_restart      - one-cycle pulse: abandon and re-measure
//   o_baud_dvsr    - divisor to baud generator (held across restart)
//   o_locked       - divisor valid and line back to idle
//   o_dvsr_valid   - one-cycle pulse on entry to LOCKED
//   o_err          - one-cycle pulse on glitch (short low) or line fault
module autobaud_detector
    import autobaud_pkg::*;
#(
    parameter int unsigned DEFAULT_DVSR = 326,
    parameter int unsigned MIN_CYC      = 32,
    parameter int unsigned MAX_CYC      = 65535,
    parameter int unsigned IDLE_CYC     = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    input  logic              i_restart,
    output logic [DVSR_W-1:0] o_baud_dvsr,
    output logic              o_locked,
    output logic              o_dvsr_valid,
    output logic              o_err
);

    logic w_rx_s;
    logic w_fall;
    logic w_rise;

    rx_sync u_rx_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_rx   (i_rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall),
        .o_rise (w_rise)
    );

    state_t              r_state,    w_state_next;
    logic [CNT_W-1:0]    r_cnt,      w_cnt_next;
    logic [IDLE_W-1:0]   r_idle_cnt, w_idle_next;
    logic [DVSR_W-1:0]   r_dvsr,     w_dvsr_next;
    logic                r_locked,   w_locked_next;
    logic                r_valid,    w_valid_next;
    logic                r_err,      w_err_next;

    logic [IDLE_W-1:0]   w_idle_inc;
    logic [IDLE_W-1:0]   w_skip_target;

    assign w_idle_inc    = r_idle_cnt + IDLE_W'(1);
    // Sixteen measured bit times of continuous high covers the rest of any
    // 10-bit character plus margin before declaring the line idle again.
    assign w_skip_target = IDLE_W'({r_cnt, OVS_SHIFT'(0)});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE_WAIT;
            r_cnt      <= '0;
            r_idle_cnt <= '0;
            r_dvsr     <= DVSR_W'(DEFAULT_DVSR);
            r_locked   <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_idle_cnt <= w_idle_next;
            r_dvsr     <= w_dvsr_next;
            r_locked   <= w_locked_next;
            r_valid    <= w_valid_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idle_next  = r_idle_cnt;
        w_dvsr_next  = r_dvsr;
        w_err_next   = 1'b0;

        case (r_state)
            IDLE_WAIT: begin
                if (w_rx_s) begin
                    if (w_idle_inc >= IDLE_W'(IDLE_CYC)) begin
                        w_state_next = WAIT_START;
                        w_idle_next  = '0;
                    end else begin
                        w_idle_next = w_idle_inc;
                    end
                end else begin
                    w_idle_next = '0;
                end
            end
            WAIT_START: begin
                // The fall cycle is the first low sample, hence cnt starts at 1.
                if (w_fall) begin
                    w_state_next = MEASURE;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (w_rise) begin
                    if (r_cnt < CNT_W'(MIN_CYC)) begin
                        w_err_next   = 1'b1;
                        w_state_next = WAIT_START;
                    end else begin
                        w_dvsr_next  = round_dvsr(r_cnt);
                        w_state_next = SKIP;
                        w_idle_next  = '0;
                    end
                end else if (r_cnt >= CNT_W'(MAX_CYC)) begin
                    w_err_next   = 1'b1;
                    w_state_next = IDLE_WAIT;
                    w_cnt_next   = '0;
                    w_idle_next  = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            SKIP: begin
                if (w_rx_s) begin
                    if (w_idle_inc >= w_skip_target) begin
                        w_state_next = LOCKED;
                    end else begin
                        w_idle_next = w_idle_inc;
                    end
                end else begin
                    w_idle_next = '0;
                end
            end
            LOCKED: begin
                w_state_next = LOCKED;
            end
            default: begin
                w_state_next = IDLE_WAIT;
                w_cnt_next   = '0;
                w_idle_next  = '0;
            end
        endcase

        // Restart overrides everything, including a measurement completing
        // in the same cycle; the divisor keeps its previous value.
        if (i_restart) begin
            w_state_next = IDLE_WAIT;
            w_cnt_next   = '0;
            w_idle_next  = '0;
            w_dvsr_next  = r_dvsr;
            w_err_next   = 1'b0;
        end

        w_locked_next = (w_state_next == LOCKED);
        w_valid_next  = (w_state_next == LOCKED) && (r_state != LOCKED);
    end

    assign o_baud_dvsr  = r_dvsr;
    assign o_locked     = r_locked;
    assign o_dvsr_valid = r_valid;
    assign o_err        = r_err;

endmodule

// File: tb/tb_autobaud_detector.sv
// Directed-plus-random bench for autobaud_detector. Expected divisors come
// from the rounding rule (cycles + 8) / 16 clamped to [2, 4095]; pulse
// counts, lock and hold behaviour come from the described operation.
module tb_autobaud_detector;

    localparam int TB_MAX  = 3000;
    localparam int TB_IDLE = 1024;
    localparam int TB_DEF  = 326;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        restart;
    logic [11:0] baud_dvsr;
    logic        locked;
    logic        dvsr_valid;
    logic        err;

    autobaud_detector #(
        .DEFAULT_DVSR (TB_DEF),
        .MIN_CYC      (32),
        .MAX_CYC      (TB_MAX),
        .IDLE_CYC     (TB_IDLE)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .i_restart    (restart),
        .o_baud_dvsr  (baud_dvsr),
        .o_locked     (locked),
        .o_dvsr_valid (dvsr_valid),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;
    int vld_seen = 0;
    int cur_dvsr = TB_DEF;

    always @(negedge clk) begin
        if (err === 1'b1)        err_seen <= err_seen + 1;
        if (dvsr_valid === 1'b1) vld_seen <= vld_seen + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int model_dvsr(input int cycles);
        int q;
        q = (cycles + 8) / 16;
        if (q < 2) q = 2;
        if (q > 4095) q = 4095;
        return q;
    endfunction

    task automatic send_frame(input int w, input logic [7:0] b);
        rx = 1'b0;
        tick(w);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(w);
        end
        rx = 1'b1;
        tick(w);
    endtask

    task automatic wait_lock(input int budget);
        int k;
        k = 0;
        while (locked !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    task automatic lock_trial(input string tag, input int w, input logic [7:0] b);
        int e0, v0, expd;
        e0   = err_seen;
        v0   = vld_seen;
        expd = model_dvsr(w);
        rx = 1'b1;
        tick(TB_IDLE + 100);
        send_frame(w, b);
        check({tag, "_early"}, 32'(locked), 32'd0);
        wait_lock(20 * w + 200);
        check({tag, "_lock"}, 32'(locked), 32'd1);
        check({tag, "_dvsr"}, 32'(baud_dvsr), 32'(expd));
        tick(2);
        check({tag, "_vld"}, 32'(vld_seen - v0), 32'd1);
        check({tag, "_err"}, 32'(err_seen - e0), 32'd0);
        cur_dvsr = expd;
        $display("trial %s width=%0d byte=%02h dvsr=%0d", tag, w, b, baud_dvsr);
    endtask

    initial begin
        int e0;
        int w;
        logic [7:0] b;

        rst = 1'b1;
        rx = 1'b1;
        restart = 1'b0;
        tick(3);
        check("rst_dvsr",  32'(baud_dvsr),  32'(TB_DEF));
        check("rst_lock",  32'(locked),     32'd0);
        check("rst_vld",   32'(dvsr_valid), 32'd0);
        check("rst_err",   32'(err),        32'd0);
        rst = 1'b0;
        tick(2);

        // 0x55 at 115200 baud.
        lock_trial("b115200", 434, 8'h55);

        // Restart while locked: locked falls next cycle, divisor held.
        pulse_restart();
        check("rs_lock_fall", 32'(locked),    32'd0);
        check("rs_lock_dvsr", 32'(baud_dvsr), 32'(cur_dvsr));

        // Random bit widths with random odd sync bytes.
        for (int t = 0; t < 3; t++) begin
            w = int'($urandom_range(250, 32));
            b = 8'($urandom) | 8'h01;
            lock_trial($sformatf("rand%0d", t), w, b);
            pulse_restart();
        end

        // Shortest accepted run.
        lock_trial("min32", 32, 8'h0D);
        pulse_restart();

        // Glitches while armed: 10 cycles, then one below MIN_CYC.
        rx = 1'b1;
        tick(TB_IDLE + 100);
        e0 = err_seen;
        rx = 1'b0; tick(10); rx = 1'b1; tick(6);
        check("glitch10_err", 32'(err_seen - e0), 32'd1);
        rx = 1'b0; tick(31); rx = 1'b1; tick(6);
        check("glitch31_err", 32'(err_seen - e0), 32'd2);
        check("glitch_dvsr",  32'(baud_dvsr), 32'(cur_dvsr));
        lock_trial("after_glitch", 100, 8'h0D);
        pulse_restart();

        // Line stuck low past MAX_CYC.
        rx = 1'b1;
        tick(TB_IDLE + 100);
        e0 = err_seen;
        rx = 1'b0;
        tick(TB_MAX + 300);
        check("stuck_err",  32'(err_seen - e0), 32'd1);
        check("stuck_lock", 32'(locked),        32'd0);
        check("stuck_dvsr", 32'(baud_dvsr),     32'(cur_dvsr));
        // Not re-armed before IDLE_CYC high: a 50-cycle low run here must not lock.
        rx = 1'b1; tick(500);
        rx = 1'b0; tick(50);
        rx = 1'b1; tick(1100);
        check("no_early_arm", 32'(locked), 32'd0);
        lock_trial("after_fault", 80, 8'h0D);
        pulse_restart();

        // Restart in the middle of MEASURE.
        rx = 1'b1;
        tick(TB_IDLE + 100);
        e0 = err_seen;
        rx = 1'b0; tick(60);
        pulse_restart();
        tick(30);
        rx = 1'b1;
        tick(1300);
        check("rsm_dvsr", 32'(baud_dvsr),     32'(cur_dvsr));
        check("rsm_lock", 32'(locked),        32'd0);
        check("rsm_err",  32'(err_seen - e0), 32'd0);

        // Restart in the very cycle the rising edge completes MEASURE.
        pulse_restart();
        rx = 1'b1;
        tick(TB_IDLE + 100);
        rx = 1'b0; tick(200);
        rx = 1'b1; tick(2);
        pulse_restart();
        tick(5);
        check("sim_rs_dvsr", 32'(baud_dvsr), 32'(cur_dvsr));
        tick(1200);
        check("sim_rs_lock", 32'(locked), 32'd0);

        // Asynchronous reset while in SKIP.
        pulse_restart();
        rx = 1'b1;
        tick(TB_IDLE + 100);
        send_frame(100, 8'h0D);
        tick(50);
        check("pre_rst_dvsr", 32'(baud_dvsr), 32'(model_dvsr(100)));
        #3;
        rst = 1'b1;
        #1;
        check("arst_dvsr", 32'(baud_dvsr),  32'(TB_DEF));
        check("arst_lock", 32'(locked),     32'd0);
        check("arst_err",  32'(err),        32'd0);
        check("arst_vld",  32'(dvsr_valid), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1700);
        check("post_rst_lock", 32'(locked),    32'd0);
        check("post_rst_dvsr", 32'(baud_dvsr), 32'(TB_DEF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/autobaud_detector.md
# autobaud_detector

Measures the start-bit width of a sync character on the raw UART rx line and produces the 16x-oversampling divisor for `baud_generator`. Sits directly upstream of the baud generator: its `baud_dvsr` output drives the generator's divisor input, and `locked` gates the UART receiver. Re-arms on `restart`. Sync character must have bit0 = 1 (e.g. 0x0D, 0x55), so the first low run is exactly one bit time.

## Interface
- `DEFAULT_DVSR`, 326: `baud_dvsr` value after reset (9600 baud at 50 MHz).
- `MIN_CYC`, 32: shortest accepted low run, in clk cycles; shorter runs are glitches.
- `MAX_CYC`, 65535: longest accepted low run; reaching it is a line fault.
- `IDLE_CYC`, 1024: continuous-high cycles required before arming.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw asynchronous serial line, idle high.
- `restart`  in  1  single-cycle pulse; abandon state and re-measure.
- `baud_dvsr`  out  12  divisor to baud generator; reset `DEFAULT_DVSR`.
- `locked`  out  1  divisor valid, line back to idle; reset 0.
- `dvsr_valid`  out  1  one-cycle pulse on entry to LOCKED; reset 0.
- `err`  out  1  one-cycle pulse on glitch or fault; reset 0.

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`); fall/rise detect on `rx_s` vs. its previous value.
- 16-bit `cnt`, 20-bit `idle_cnt`.
- States:
  - IDLE_WAIT (reset state): `idle_cnt` counts cycles of `rx_s`=1 and clears on `rx_s`=0. At `IDLE_CYC` go to WAIT_START.
  - WAIT_START: on falling edge go to MEASURE with `cnt`=1.
  - MEASURE: `cnt`++ each cycle while `rx_s`=0.
    - If `cnt` reaches `MAX_CYC` with the line still low: pulse `err`, go to IDLE_WAIT.
    - On rising edge with `cnt` < `MIN_CYC`: pulse `err`, go to WAIT_START.
    - Otherwise: `baud_dvsr` <= (`cnt`+8)>>4, clamped to [2, 4095]; go to SKIP.
  - SKIP: wait for the rest of the character. `idle_cnt` counts continuous `rx_s`=1 and clears on low. At `cnt`<<4 (16 bit times) go to LOCKED.
  - LOCKED: `locked`=1 and `dvsr_valid` pulses on the entry cycle. Line activity is ignored.
- `restart` in any state: next cycle go to IDLE_WAIT, `locked`=0, counters cleared.
- `baud_dvsr` keeps its last value until a new successful measurement. `restart` never reverts it to `DEFAULT_DVSR`; only `rst` does.
- Rounding is exact half-up at 1/16 granularity. The clamp applies before the register.
- Simultaneous `restart` and measurement completion: `restart` wins and `baud_dvsr` is not updated.

## Timing
- rx to `rx_s`: 2 cycles. Measured `cnt` equals the true low width; the latency cancels on both edges.
- `baud_dvsr` updates in the cycle after the rising edge is detected in MEASURE.
- `locked` and `dvsr_valid` assert the cycle after `idle_cnt` reaches threshold in SKIP.
- `err` is registered and asserts the cycle after the fault condition.
- `rst` asynchronously forces IDLE_WAIT and the reset values on all outputs, mid-measurement included. Release is synchronous to `clk`.
- Downstream baud generator resets its own counter on divisor change, so no extra handshake is needed.

## Structure
- Package `autobaud_pkg`:
  - state enum (IDLE_WAIT, WAIT_START, MEASURE, SKIP, LOCKED);
  - width constants `CNT_W`=16, `IDLE_W`=20, `DVSR_W`=12;
  - oversample shift constant 4.
- Sub-module `rx_sync`: 2-FF synchronizer with registered previous value, outputs `rx_s`, `fall`, `rise`. Reset value high (idle).

## Test plan
All scenarios at 50 MHz clk.
- 0x0D at 9600 baud (5208 cycles/bit) after 2000 idle cycles -> `baud_dvsr`=326; `locked` rises about 16 bit times after the stop bit; one `dvsr_valid` pulse.
- 0x55 at 115200 (434 cycles/bit) -> `baud_dvsr`=27, `locked`=1.
- 10-cycle low glitch during WAIT_START -> one `err` pulse, state WAIT_START. A following 0x0D at 19200 (2604 cycles/bit) -> 163.
- rx held low 70000 cycles -> `err` at `cnt`=65535, `locked`=0, `baud_dvsr` unchanged. Lock occurs only after `IDLE_CYC` high.
- `restart` mid-MEASURE -> no `baud_dvsr` update, IDLE_WAIT. `restart` while LOCKED -> `locked` falls the next cycle and `baud_dvsr` is held.
- `rst` pulsed mid-SKIP -> `baud_dvsr`=326, `locked`/`err`/`dvsr_valid`=0 immediately, without waiting for a clk edge.
